// File: rtl/fb_rect_writer.sv
// Rectangle fill engine for a 1-bpp framebuffer: one byte write per clock, raster order.
// Commands arrive over valid/ready; hold stalls the write stream without losing position.
module fb_rect_writer #(
    parameter int X_W = 4,
    parameter int Y_W = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [X_W-1:0]     cmd_x0,
    input  logic [X_W-1:0]     cmd_x1,
    input  logic [Y_W-1:0]     cmd_y0,
    input  logic [Y_W-1:0]     cmd_y1,
    input  logic [7:0]         cmd_data,
    input  logic               hold,
    output logic               wr_en,
    output logic [X_W+Y_W-1:0] wr_addr,
    output logic [7:0]         wr_data,
    output logic               busy,
    output logic               done
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] OP_CLEAR  = 2'b01;
    localparam logic [1:0] OP_STRIPE = 2'b10;
    localparam logic [1:0] OP_RSVD   = 2'b11;

    state_t         state, state_next;
    logic [X_W-1:0] x0_r, x1_r, cur_x;
    logic [Y_W-1:0] y1_r, cur_y;
    logic [7:0]     fill_r;
    logic           stripe_r;
    logic           fin;

    logic           accept, empty, issue, last_pos, wrap_x, stripe_sel;
    logic [X_W-1:0] sx0, sx1, pos_x, base_x0, lim_x1, nxt_x;
    logic [Y_W-1:0] sy0, sy1, pos_y, lim_y1, nxt_y;
    logic [7:0]     fill_sel, wdata;

    assign cmd_ready = (state == IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // CLEAR is simply a RECT spanning the whole framebuffer.
    assign sx0   = (cmd_op == OP_CLEAR) ? '0 : cmd_x0;
    assign sx1   = (cmd_op == OP_CLEAR) ? '1 : cmd_x1;
    assign sy0   = (cmd_op == OP_CLEAR) ? '0 : cmd_y0;
    assign sy1   = (cmd_op == OP_CLEAR) ? '1 : cmd_y1;
    assign empty = (cmd_op == OP_RSVD) || (sx0 > sx1) || (sy0 > sy1);

    // The first write is issued straight from the command fields on the acceptance edge.
    assign pos_x      = (state == IDLE) ? sx0 : cur_x;
    assign pos_y      = (state == IDLE) ? sy0 : cur_y;
    assign base_x0    = (state == IDLE) ? sx0 : x0_r;
    assign lim_x1     = (state == IDLE) ? sx1 : x1_r;
    assign lim_y1     = (state == IDLE) ? sy1 : y1_r;
    assign fill_sel   = (state == IDLE) ? cmd_data : fill_r;
    assign stripe_sel = (state == IDLE) ? (cmd_op == OP_STRIPE) : stripe_r;

    assign issue    = (state == IDLE) ? (accept && !empty) : (!fin && !hold);
    assign wrap_x   = (pos_x == lim_x1);
    assign last_pos = wrap_x && (pos_y == lim_y1);
    assign nxt_x    = wrap_x ? base_x0 : pos_x + X_W'(1);
    assign nxt_y    = wrap_x ? pos_y + Y_W'(1) : pos_y;
    assign wdata    = fill_sel ^ {8{stripe_sel & pos_y[0]}};

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept && !empty) state_next = RUN;
            RUN:     if (fin) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fin      <= 1'b0;
            cur_x    <= '0;
            cur_y    <= '0;
            x0_r     <= '0;
            x1_r     <= '0;
            y1_r     <= '0;
            fill_r   <= '0;
            stripe_r <= 1'b0;
        end else begin
            wr_en <= issue;
            done  <= 1'b0;
            if (issue) begin
                wr_addr <= {pos_y, pos_x};
                wr_data <= wdata;
                cur_x   <= nxt_x;
                cur_y   <= nxt_y;
                fin     <= last_pos;
            end
            if (state == IDLE && accept) begin
                x0_r     <= sx0;
                x1_r     <= sx1;
                y1_r     <= sy1;
                fill_r   <= cmd_data;
                stripe_r <= (cmd_op == OP_STRIPE);
                busy     <= !empty;
                done     <= empty;
            end
            // fin means the final write is on the bus this cycle; wrap up on this edge.
            if (state == RUN && fin) begin
                busy <= 1'b0;
                done <= 1'b1;
                fin  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: per-scenario tasks with inline checks against
// hand-computed write sequences, sampled on the falling edge.
module tb_fb_rect_writer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [3:0]  cmd_x0 = '0, cmd_x1 = '0;
    logic [6:0]  cmd_y0 = '0, cmd_y1 = '0;
    logic [7:0]  cmd_data = '0;
    logic        hold = 1'b0;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy, done;

    int total = 0;
    int bad = 0;
    logic [7:0] ram [2048];

    fb_rect_writer #(.X_W(4), .Y_W(7)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0),
        .cmd_y1(cmd_y1), .cmd_data(cmd_data), .hold(hold), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (wr_en) ram[wr_addr] <= wr_data;

    task automatic set_cmd(input logic [1:0] op, input logic [3:0] x0, input logic [3:0] x1,
                           input logic [6:0] y0, input logic [6:0] y1, input logic [7:0] d);
        cmd_op = op; cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1; cmd_data = d;
        cmd_valid = 1'b1;
    endtask

    // Presents a command for one cycle; returns just after the acceptance edge T.
    task automatic send(input logic [1:0] op, input logic [3:0] x0, input logic [3:0] x1,
                        input logic [6:0] y0, input logic [6:0] y1, input logic [7:0] d);
        @(negedge clk);
        set_cmd(op, x0, x1, y0, y1, d);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({wr_en, wr_addr, wr_data, busy, done} !== 22'd0) begin
            bad++;
            $display("FAIL reset_outputs: got en=%b addr=%0d data=%h busy=%b done=%b expected all 0",
                     wr_en, wr_addr, wr_data, busy, done);
        end
        total++;
        if (cmd_ready !== 1'b0) begin
            bad++; $display("FAIL reset_ready_low: got %b expected 0", cmd_ready);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready_after: got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_rect;
        logic [10:0] exp_a [6] = '{11'd162, 11'd163, 11'd164, 11'd178, 11'd179, 11'd180};
        send(2'b00, 4'd2, 4'd4, 7'd10, 7'd11, 8'hA5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== exp_a[i] || wr_data !== 8'hA5 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL rect_write[%0d]: got en=%b addr=%0d data=%h busy=%b done=%b expected en=1 addr=%0d data=a5 busy=1 done=0",
                         i, wr_en, wr_addr, wr_data, busy, done, exp_a[i]);
            end
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rect_done: got en=%b done=%b ready=%b busy=%b expected 0 1 1 0",
                     wr_en, done, cmd_ready, busy);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || wr_en !== 1'b0) begin
            bad++; $display("FAIL rect_done_pulse: got done=%b en=%b expected 0 0", done, wr_en);
        end
    endtask

    task automatic test_clear;
        int nz;
        for (int i = 0; i < 2048; i++) ram[i] = 8'hFF;
        send(2'b01, 4'd7, 4'd3, 7'd9, 7'd2, 8'h00);
        for (int i = 0; i < 2048; i++) begin
            @(negedge clk);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 11'(i) || wr_data !== 8'h00 || done !== 1'b0) begin
                bad++;
                $display("FAIL clear_write[%0d]: got en=%b addr=%0d data=%h done=%b expected en=1 addr=%0d data=00 done=0",
                         i, wr_en, wr_addr, wr_data, done, i);
            end
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL clear_done: got en=%b done=%b expected 0 1", wr_en, done);
        end
        nz = 0;
        for (int i = 0; i < 2048; i++) if (ram[i] !== 8'h00) nz++;
        total++;
        if (nz != 0) begin
            bad++; $display("FAIL clear_ram: got %0d nonzero bytes expected 0", nz);
        end
    endtask

    task automatic test_stripe;
        logic [10:0] exp_a [4] = '{11'd48, 11'd64, 11'd80, 11'd96};
        logic [7:0]  exp_d [4] = '{8'hF0, 8'h0F, 8'hF0, 8'h0F};
        send(2'b10, 4'd0, 4'd0, 7'd3, 7'd6, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== exp_a[i] || wr_data !== exp_d[i]) begin
                bad++;
                $display("FAIL stripe_write[%0d]: got en=%b addr=%0d data=%h expected en=1 addr=%0d data=%h",
                         i, wr_en, wr_addr, wr_data, exp_a[i], exp_d[i]);
            end
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL stripe_done: got en=%b done=%b expected 0 1", wr_en, done);
        end
    endtask

    task automatic test_hold;
        // cycle index relative to acceptance edge T; expected write address or -1 for none
        int exp_a [8] = '{320, 321, -1, -1, -1, 322, 323, -1};
        send(2'b00, 4'd0, 4'd3, 7'd20, 7'd20, 8'h3C);
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin hold = 1'b1; end
            if (c == 5) begin hold = 1'b0; end
            @(negedge clk);
            total++;
            if (c <= 7 && exp_a[c-1] >= 0) begin
                if (wr_en !== 1'b1 || wr_addr !== 11'(exp_a[c-1]) || wr_data !== 8'h3C || busy !== 1'b1) begin
                    bad++;
                    $display("FAIL hold_write[T+%0d]: got en=%b addr=%0d data=%h busy=%b expected en=1 addr=%0d data=3c busy=1",
                             c, wr_en, wr_addr, wr_data, busy, exp_a[c-1]);
                end
            end else if (c <= 7) begin
                if (wr_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL hold_stall[T+%0d]: got en=%b busy=%b done=%b expected 0 1 0",
                             c, wr_en, busy, done);
                end
            end else begin
                if (wr_en !== 1'b0 || done !== 1'b1) begin
                    bad++; $display("FAIL hold_done: got en=%b done=%b expected 0 1", wr_en, done);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_empty;
        logic [1:0] ops [3] = '{2'b00, 2'b11, 2'b10};
        logic [3:0] x0s [3] = '{4'd5, 4'd1, 4'd0};
        logic [3:0] x1s [3] = '{4'd3, 4'd2, 4'd0};
        logic [6:0] y0s [3] = '{7'd0, 7'd4, 7'd9};
        logic [6:0] y1s [3] = '{7'd0, 7'd4, 7'd8};
        for (int k = 0; k < 3; k++) begin
            send(ops[k], x0s[k], x1s[k], y0s[k], y1s[k], 8'hC3);
            @(negedge clk);
            total++;
            if (wr_en !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL empty_t1[%0d]: got en=%b done=%b ready=%b busy=%b expected 0 1 1 0",
                         k, wr_en, done, cmd_ready, busy);
            end
            @(negedge clk);
            total++;
            if (wr_en !== 1'b0 || done !== 1'b0) begin
                bad++; $display("FAIL empty_t2[%0d]: got en=%b done=%b expected 0 0", k, wr_en, done);
            end
        end
    endtask

    task automatic test_back_to_back;
        send(2'b00, 4'd7, 4'd7, 7'd1, 7'd1, 8'h11);
        @(negedge clk);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd23 || wr_data !== 8'h11 || cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first: got en=%b addr=%0d data=%h ready=%b expected 1 23 11 0",
                     wr_en, wr_addr, wr_data, cmd_ready);
        end
        @(posedge clk); #1;
        set_cmd(2'b10, 4'd5, 4'd5, 7'd1, 7'd1, 8'h55);
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || done !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_gap: got en=%b done=%b ready=%b expected 0 1 1", wr_en, done, cmd_ready);
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd21 || wr_data !== 8'hAA || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_second: got en=%b addr=%0d data=%h done=%b expected 1 21 aa 0",
                     wr_en, wr_addr, wr_data, done);
        end
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || done !== 1'b1) begin
            bad++; $display("FAIL b2b_done: got en=%b done=%b expected 0 1", wr_en, done);
        end
    endtask

    task automatic test_reset_mid;
        int stray;
        send(2'b01, 4'd0, 4'd0, 7'd0, 7'd0, 8'h77);
        repeat (19) @(negedge clk);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd18) begin
            bad++; $display("FAIL mid_w19: got en=%b addr=%0d expected 1 18", wr_en, wr_addr);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        total++;
        if (wr_en !== 1'b1 || wr_addr !== 11'd19) begin
            bad++; $display("FAIL mid_w20: got en=%b addr=%0d expected 1 19", wr_en, wr_addr);
        end
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if (wr_en !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL mid_after: got en=%b done=%b busy=%b ready=%b expected 0 0 0 1",
                     wr_en, done, busy, cmd_ready);
        end
        stray = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr_en !== 1'b0 || done !== 1'b0) stray++;
        end
        total++;
        if (stray != 0) begin
            bad++; $display("FAIL mid_quiet: got %0d active cycles expected 0", stray);
        end
        send(2'b00, 4'd8, 4'd9, 7'd0, 7'd0, 8'h99);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (wr_en !== 1'b1 || wr_addr !== 11'(8 + i) || wr_data !== 8'h99) begin
                bad++;
                $display("FAIL mid_rect[%0d]: got en=%b addr=%0d data=%h expected 1 %0d 99",
                         i, wr_en, wr_addr, wr_data, 8 + i);
            end
        end
        @(negedge clk);
        total++;
        if (done !== 1'b1 || wr_en !== 1'b0) begin
            bad++; $display("FAIL mid_rect_done: got done=%b en=%b expected 1 0", done, wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_rect();
        test_clear();
        test_stripe();
        test_hold();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
